// File: rtl/conv_encoder_framer_pkg.sv
// Shared convolutional-code definitions (K=7, rate 1/2) for the encoder/framer and the Viterbi decoder.
package conv_code_pkg;

    localparam int K = 7;
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;
    localparam int SOFT_W = 3;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    // Hard decision to soft value: 0 -> strong zero, 1 -> strong one.
    function automatic logic [SOFT_W-1:0] soft_map(input logic b);
        return {SOFT_W{b}};
    endfunction

endpackage

// File: rtl/conv_encoder_framer_if.sv
// Byte-in / soft-symbol-out stream bundle of the convolutional encoder framer.
interface conv_encoder_framer_if;
    import conv_code_pkg::*;

    logic [7:0]          s_data;
    logic                s_last;
    logic                s_valid;
    logic                s_ready;
    logic [2*SOFT_W-1:0] m_sym;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (
        output s_data, s_last, s_valid, m_ready,
        input  s_ready, m_sym, m_valid, m_last
    );

    modport slave (
        input  s_data, s_last, s_valid, m_ready,
        output s_ready, m_sym, m_valid, m_last
    );

endinterface

// File: rtl/conv_encoder_framer_core.sv
// Encoder core: parity taps over {u, sr} and the K-1 bit state register advanced per issued symbol.
module conv_enc_core
    import conv_code_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_u,
    input  logic i_adv,
    output logic o_c0,
    output logic o_c1
);

    logic [K-2:0] r_sr;
    logic [K-1:0] w_reg;

    assign w_reg = {i_u, r_sr};
    assign o_c0  = ^(w_reg & G0);
    assign o_c1  = ^(w_reg & G1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_adv) begin
            r_sr <= w_reg[K-1:1];
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// K=7 rate-1/2 convolutional encoder with byte serializer, one-entry hold buffer and zero-tail framing.
module conv_encoder_framer
    import conv_code_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    conv_encoder_framer_if.slave  bus,
    output logic                  busy
);

    state_t              r_state, w_state_nxt;
    logic [7:0]          r_work, w_work_nxt;
    logic                r_work_last, w_work_last_nxt;
    logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]          r_tail_cnt, w_tail_cnt_nxt;
    logic [7:0]          r_hold_byte, w_hold_byte_nxt;
    logic                r_hold_last, w_hold_last_nxt;
    logic                r_hold_valid, w_hold_valid_nxt;
    logic [2*SOFT_W-1:0] r_m_sym;
    logic                r_m_valid, r_m_last;

    logic w_acc, w_out_free, w_work_empty, w_refill;
    logic w_issue, w_u, w_sym_last, w_c0, w_c1;

    assign bus.s_ready  = !rst && !r_hold_valid;
    assign w_acc        = bus.s_valid && bus.s_ready;
    assign w_out_free   = !r_m_valid || bus.m_ready;
    assign w_work_empty = (r_state == IDLE) || ((r_state == DATA) && (r_bit_cnt == 4'd8));

    conv_enc_core u_core (
        .clk   (clk),
        .rst   (rst),
        .i_u   (w_u),
        .i_adv (w_issue),
        .o_c0  (w_c0),
        .o_c1  (w_c1)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_work_nxt       = r_work;
        w_work_last_nxt  = r_work_last;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_tail_cnt_nxt   = r_tail_cnt;
        w_hold_byte_nxt  = r_hold_byte;
        w_hold_last_nxt  = r_hold_last;
        w_hold_valid_nxt = r_hold_valid;
        w_issue          = 1'b0;
        w_u              = 1'b0;
        w_sym_last       = 1'b0;
        w_refill         = 1'b0;

        if (w_acc && !w_work_empty) begin
            w_hold_byte_nxt  = bus.s_data;
            w_hold_last_nxt  = bus.s_last;
            w_hold_valid_nxt = 1'b1;
        end

        case (r_state)
            IDLE, DATA: begin
                if (w_work_empty) begin
                    // Empty working register: a fresh byte encodes its MSB in the accept cycle.
                    if (w_acc) begin
                        w_state_nxt     = DATA;
                        w_work_last_nxt = bus.s_last;
                        if (w_out_free) begin
                            w_issue       = 1'b1;
                            w_u           = bus.s_data[7];
                            w_work_nxt    = {bus.s_data[6:0], 1'b0};
                            w_bit_cnt_nxt = 4'd1;
                        end else begin
                            w_work_nxt    = bus.s_data;
                            w_bit_cnt_nxt = 4'd0;
                        end
                    end
                end else if (w_out_free) begin
                    w_issue       = 1'b1;
                    w_u           = r_work[7];
                    w_work_nxt    = {r_work[6:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        if (r_work_last) begin
                            w_state_nxt    = TAIL;
                            w_tail_cnt_nxt = 3'd0;
                        end else begin
                            w_refill = 1'b1;
                        end
                    end
                end
            end
            TAIL: begin
                if (w_out_free) begin
                    w_issue        = 1'b1;
                    w_tail_cnt_nxt = r_tail_cnt + 3'd1;
                    if (r_tail_cnt == 3'(K-2)) begin
                        w_sym_last  = 1'b1;
                        w_state_nxt = IDLE;
                        w_refill    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Refill the working register at a byte boundary; with nothing pending DATA idles at bit_cnt=8.
        if (w_refill) begin
            if (r_hold_valid) begin
                w_work_nxt       = r_hold_byte;
                w_work_last_nxt  = r_hold_last;
                w_bit_cnt_nxt    = 4'd0;
                w_hold_valid_nxt = 1'b0;
                w_state_nxt      = DATA;
            end else if (w_acc) begin
                w_work_nxt       = bus.s_data;
                w_work_last_nxt  = bus.s_last;
                w_bit_cnt_nxt    = 4'd0;
                w_hold_valid_nxt = 1'b0;
                w_state_nxt      = DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_work       <= '0;
            r_work_last  <= 1'b0;
            r_bit_cnt    <= '0;
            r_tail_cnt   <= '0;
            r_hold_byte  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_m_sym      <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_work       <= w_work_nxt;
            r_work_last  <= w_work_last_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tail_cnt   <= w_tail_cnt_nxt;
            r_hold_byte  <= w_hold_byte_nxt;
            r_hold_last  <= w_hold_last_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            if (w_issue) begin
                r_m_sym   <= {soft_map(w_c0), soft_map(w_c1)};
                r_m_valid <= 1'b1;
                r_m_last  <= w_sym_last;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign bus.m_sym   = r_m_sym;
    assign bus.m_valid = r_m_valid;
    assign bus.m_last  = r_m_last;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed and randomized checks of conv_encoder_framer against a convolution-sum reference model.
module tb_conv_encoder_framer;

    localparam logic [6:0] TG0 = 7'o171;
    localparam logic [6:0] TG1 = 7'o133;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic rand_rdy;

    conv_encoder_framer_if bus ();

    conv_encoder_framer dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [6:0] rx_q [$];
    int         rx_cyc [$];
    logic [6:0] exp_q [$];
    logic [7:0] frame_q [$];
    logic [5:0] imp_ref [14] = '{6'h3F, 6'h38, 6'h3F, 6'h3F, 6'h00, 6'h07, 6'h3F,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    always @(posedge clk) cyc <= cyc + 1;

    // Record every symbol handshake as {m_last, m_sym}.
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            rx_q.push_back({bus.m_last, bus.m_sym});
            rx_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each code bit is a mod-2 convolution of the frame bit stream with the generator taps.
    task automatic model_frame();
        bit   bits [$];
        logic c0, c1;
        bits = {};
        foreach (frame_q[j]) for (int i = 7; i >= 0; i--) bits.push_back(frame_q[j][i]);
        for (int i = 0; i < 6; i++) bits.push_back(1'b0);
        for (int n = 0; n < bits.size(); n++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int t = 0; t < 7; t++) begin
                if (n - t >= 0) begin
                    c0 = c0 ^ (TG0[6-t] & bits[n-t]);
                    c1 = c1 ^ (TG1[6-t] & bits[n-t]);
                end
            end
            exp_q.push_back({(n == bits.size() - 1), {3{c0}}, {3{c1}}});
        end
    endtask

    task automatic clear_all();
        rx_q = {};
        rx_cyc = {};
        exp_q = {};
        frame_q = {};
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 300) begin
                chk("send_timeout", 32'(bus.s_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frame_q[j]) begin
            send_byte(frame_q[j], (j == frame_q.size() - 1));
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            #1;
        end
    endtask

    function automatic int count_lasts();
        int c;
        c = 0;
        foreach (rx_q[i]) if (rx_q[i][6]) c++;
        return c;
    endfunction

    task automatic wait_lasts(input int n, input int budget);
        int t;
        t = 0;
        while (count_lasts() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (count_lasts() < n) chk("frame_timeout", 32'(count_lasts()), 32'(n));
    endtask

    task automatic compare_rx(input string tag);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_sym%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_impulse(input string tag);
        chk({tag, "_len14"}, 32'(rx_q.size()), 32'd14);
        for (int i = 0; i < 14 && i < rx_q.size(); i++)
            chk($sformatf("%s_const%0d", tag, i), 32'(rx_q[i][5:0]), 32'(imp_ref[i]));
    endtask

    initial begin
        rst         = 1'b1;
        rand_rdy    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_sym",   32'(bus.m_sym),   32'd0);
        chk("rst_m_last",  32'(bus.m_last),  32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Impulse
        clear_all();
        frame_q = '{8'h80};
        model_frame();
        send_byte(8'h80, 1'b1);
        wait_lasts(1, 100);
        @(negedge clk);
        chk("imp_busy_after", 32'(busy), 32'd0);
        chk("imp_sr_zero", 32'(dut.u_core.r_sr), 32'd0);
        compare_rx("imp");
        check_impulse("imp");
        @(posedge clk);
        #1;

        // Zero frame
        clear_all();
        frame_q = '{8'h00};
        model_frame();
        send_byte(8'h00, 1'b1);
        wait_lasts(1, 100);
        compare_rx("zero");
        @(posedge clk);
        #1;

        // Back-to-back two-byte frame
        clear_all();
        frame_q = '{8'hA5, 8'h3C};
        model_frame();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        chk("b2b_s_ready_hold_full", 32'(bus.s_ready), 32'd0);
        wait_lasts(1, 100);
        compare_rx("b2b");
        if (rx_cyc.size() == 22) chk("b2b_contiguous", 32'(rx_cyc[21] - rx_cyc[0]), 32'd21);
        @(posedge clk);
        #1;

        // Backpressure at symbol 3 of the impulse
        clear_all();
        frame_q = '{8'h80};
        model_frame();
        send_byte(8'h80, 1'b1);
        for (int t = 0; t < 50 && rx_q.size() < 2; t++) begin
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), 32'(bus.m_valid), 32'd1);
            chk($sformatf("bp_sym%0d", i), 32'(bus.m_sym), 32'h3F);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        wait_lasts(1, 100);
        compare_rx("bp");
        check_impulse("bp");
        @(posedge clk);
        #1;

        // Starvation between bytes of one frame
        clear_all();
        frame_q = '{8'hFF, 8'h00};
        model_frame();
        send_byte(8'hFF, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("starve_gap_valid", 32'(bus.m_valid), 32'd0);
        chk("starve_gap_busy",  32'(busy),        32'd1);
        chk("starve_no_tail",   32'(rx_q.size()), 32'd8);
        send_byte(8'h00, 1'b1);
        wait_lasts(1, 100);
        compare_rx("starve");
        @(posedge clk);
        #1;

        // Reset in the middle of a frame
        clear_all();
        send_byte(8'hFF, 1'b1);
        for (int t = 0; t < 50 && rx_q.size() < 5; t++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_busy",    32'(busy),        32'd0);
        rst = 1'b0;
        clear_all();
        frame_q = '{8'h80};
        model_frame();
        send_byte(8'h80, 1'b1);
        wait_lasts(1, 100);
        compare_rx("midrst");
        check_impulse("midrst");
        @(posedge clk);
        #1;

        // Randomized frames with random gaps and random m_ready
        clear_all();
        rand_rdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            frame_q = {};
            repeat ($urandom_range(1, 3)) frame_q.push_back(8'($urandom));
            model_frame();
            send_frame(3);
        end
        wait_lasts(4, 3000);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        compare_rx("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Transmit-side counterpart of the Viterbi decoder: a K=7, rate-1/2 convolutional encoder with frame termination.
- Takes bytes over a valid/ready stream and serializes them MSB-first.
- Emits one coded symbol pair per cycle as hard-mapped soft values. The output format is 2x3 bits, so the encoder output feeds the decoder's 6-bit soft input directly for loopback.
- Appends K-1 zero tail bits per frame so the decoder's trellis ends in state 0.

Parameters:
- K, 7, constraint length.
- G0, 7'o171, generator polynomial for the first code bit (bit K-1 weights the current input).
- G1, 7'o133, generator polynomial for the second code bit.
- SOFT_W, 3, soft width per code bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of a frame; qualified by s_valid.
- s_valid  in  1  input byte valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- m_sym  out  2*SOFT_W  {soft(c0), soft(c1)}, c0 in the MSBs.
- m_valid  out  1  symbol valid.
- m_ready  in  1  symbol consumed when m_valid && m_ready.
- m_last  out  1  high on the final tail symbol of a frame.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values (at the rst clock edge): m_valid=0, m_sym=0, m_last=0, busy=0, s_ready=0 while rst is high. Encoder state sr (K-1 bits), bit counter, hold buffer and FSM are cleared.
- Reset mid-frame aborts the frame: no tail is emitted, partial data is discarded, sr=0.
- Storage:
  - Working byte shift register with bit_cnt 0..7.
  - One-entry hold buffer {byte, last, hold_valid}.
- s_ready: s_ready = !rst && !hold_valid. A byte accepted while the working register is busy goes into the hold buffer.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: on byte accept, load the working register directly and go to DATA. The first symbol has m_valid=1 in the next cycle (latency 1).
  - DATA: each time the output register is free (!m_valid || m_ready), encode the next bit and register it.
  - When the 8th bit is issued:
    - if the current byte carried last, go to TAIL with tail_cnt=0;
    - else if hold_valid, load the held byte (hold_valid<=0) and continue with no bubble;
    - else stall with m_valid deasserting after consumption. Wait in DATA with bit_cnt=8 (empty) and no tail insertion, resuming on the next byte.
  - TAIL: encode u=0 for K-1 symbols. Assert m_last with the (K-1)th. On its issue, sr must already be 0; go to DATA if hold_valid, else IDLE.
- Encoding:
  - reg = {u, sr}, with u at bit K-1.
  - c0 = ^(reg & G0), c1 = ^(reg & G1).
  - sr <= reg[K-1:1] on each issued symbol.
- Soft map: bit 0 -> all-zeros (strong 0), bit 1 -> all-ones (strong 1).
- Output register holds m_sym/m_last stable while m_valid && !m_ready.
- Throughput: 1 symbol/cycle with m_ready=1 and bytes supplied in time. A frame of N bytes gives 8N+K-1 symbols.
- Simultaneous events:
  - A byte accept in the same cycle the working register empties: the byte goes straight to the working register with no bubble, and the hold buffer stays empty.
  - A new frame's first byte may be accepted during TAIL (into the hold buffer). It starts with sr=0 immediately after m_last.

Decomposition:
- Package conv_code_pkg holds K, G0, G1, SOFT_W, the state enum {IDLE, DATA, TAIL}, and the soft-map function. The Viterbi decoder shares it so both ends use the same polynomials.
- One sub-module, conv_enc_core: the combinational c0/c1 computation plus the sr register with an advance enable.

Test Plan:
- Impulse: byte 0x80 with last, m_ready=1.
  - Expect 14 symbols: 3F, 38, 3F, 3F, 00, 07, 3F, then 7x 00.
  - m_last only on the 14th symbol; sr=0 afterwards; busy drops the next cycle.
- Zero frame: byte 0x00 with last -> 14x m_sym=00, m_last on the 14th.
- Back-to-back: bytes 0xA5, 0x3C (last) offered continuously.
  - Expect 22 contiguous valid cycles.
  - Output equals a reference model of the 16-bit sequence plus 6 zeros.
  - s_ready low while the hold buffer is full.
- Backpressure: during the impulse test hold m_ready=0 for 5 cycles at symbol 3. m_sym must stay 3F with m_valid=1, and the full sequence must be unchanged after release.
- Starvation: first byte 0xFF (no last), second byte 0x00 (last) presented 10 cycles later.
  - Expect a gap with m_valid=0 and no tail inserted.
  - The total of 22 symbols must match the model.
- Reset mid-frame: assert rst after symbol 5 of 0xFF.
  - Next cycle m_valid=0 and busy=0.
  - A new 0x80 frame reproduces the impulse sequence exactly.
